// File: rtl/conv1_sched_pkg.sv
// Shared constants, FSM state type and window slot helper for the conv1 sequencer.
// The optional column-reuse fetch is enabled with CONV1_SCHED_WINDOW_REUSE_EN.
package conv1_sched_pkg;
   localparam int DEF_IMG_W  = 32;
   localparam int DEF_IMG_H  = 32;
   localparam int KS         = 5;
   localparam int PIX_W      = 16;
   localparam int N_CH       = 6;
   localparam int OW         = DEF_IMG_W - KS + 1;
   localparam int OH         = DEF_IMG_H - KS + 1;
   localparam int WIN_SLOTS  = KS * KS;
   localparam int ACT_W      = WIN_SLOTS * PIX_W;
   localparam int OUT_W_BITS = N_CH * PIX_W;
   localparam int SLOT_W     = $clog2(WIN_SLOTS);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_DRAIN    = 3'd2,
      S_ISSUE    = 3'd3,
      S_WAIT_RES = 3'd4,
      S_DONE     = 3'd5
   } conv1_sched_state_t;

   // Slot numbering is kr-major, matching the packing of conv1.input_act.
   function automatic logic [SLOT_W-1:0] slot_idx(input int unsigned kr, input int unsigned kc);
      int unsigned v;
      v = kr * KS + kc;
      return v[SLOT_W-1:0];
   endfunction
endpackage

// File: rtl/conv1_window_reg.sv
// 5x5 window storage: single-slot write, one-column left shift, flat activation output.
module conv1_window_reg
   import conv1_sched_pkg::*;
#(
   parameter int K      = KS,
   parameter int DATA_W = PIX_W
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    i_wr_en,
   input  logic [SLOT_W-1:0]       i_wr_slot,
   input  logic [DATA_W-1:0]       i_wr_data,
   input  logic                    i_shift,
   output logic [K*K*DATA_W-1:0]   o_act
);
   logic [DATA_W-1:0] r_win [K*K];

   // The rightmost column keeps its value on a shift; it is refilled by the next fetch.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < K*K; i++) r_win[i] <= '0;
      end else if (i_shift) begin
         for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K-1; kc++)
               r_win[kr*K+kc] <= r_win[kr*K+kc+1];
      end else if (i_wr_en) begin
         r_win[i_wr_slot] <= i_wr_data;
      end
   end

   for (genvar i = 0; i < K*K; i++) begin : g_flat
      assign o_act[i*DATA_W +: DATA_W] = r_win[i];
   end
endmodule

// File: rtl/conv1_sched.sv
// Scans the image row-major, fetches each 5x5 window, issues it to conv1 and stores the result.
// Define CONV1_SCHED_WINDOW_REUSE_EN to refetch only the new column when c > 0.
module conv1_sched
   import conv1_sched_pkg::*;
#(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int K      = 5,
   parameter int DATA_W = 16,
   parameter int OUT_CH = 6
) (
   input  logic                                         clk,
   input  logic                                         rstn,
   input  logic                                         start,
   output logic                                         busy,
   output logic                                         done,
   output logic                                         img_rd_en,
   output logic [$clog2(IMG_W*IMG_H)-1:0]               img_rd_addr,
   input  logic [DATA_W-1:0]                            img_rd_data,
   output logic                                         conv_valid,
   output logic [K*K*DATA_W-1:0]                        conv_act,
   input  logic                                         conv_ready,
   input  logic [OUT_CH*DATA_W-1:0]                     conv_out,
   output logic                                         out_wr_en,
   output logic [$clog2((IMG_W-K+1)*(IMG_H-K+1))-1:0]   out_wr_addr,
   output logic [OUT_CH*DATA_W-1:0]                     out_wr_data
);
   localparam int L_OW = IMG_W - K + 1;
   localparam int L_OH = IMG_H - K + 1;
   localparam int AW   = $clog2(IMG_W*IMG_H);
   localparam int OAW  = $clog2(L_OW*L_OH);
   localparam int RW   = $clog2(L_OH);
   localparam int CW   = $clog2(L_OW);
   localparam int KW   = $clog2(K);

   conv1_sched_state_t r_state;
   logic [RW-1:0]      r_r;
   logic [CW-1:0]      r_c;
   logic [KW-1:0]      r_kr, r_kc;
   logic               r_reuse, r_cap_vld;
   logic [SLOT_W-1:0]  r_cap_slot;

   logic               w_last_col, w_last_pos, w_next_reuse, w_last_rd, w_shift;
   logic [RW-1:0]      w_nr;
   logic [CW-1:0]      w_nc;
   logic [KW-1:0]      w_nkr, w_nkc, w_first_kc;
   logic [OAW-1:0]     w_out_addr;
   int unsigned        w_out_lin;

   function automatic logic [AW-1:0] pix_addr(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                              input logic [KW-1:0] kr, input logic [KW-1:0] kc);
      int unsigned a;
      a = (32'(r) + 32'(kr)) * 32'(IMG_W) + 32'(c) + 32'(kc);
      return a[AW-1:0];
   endfunction

   always_comb begin
      w_last_col = (r_c == CW'(L_OW-1));
      w_last_pos = w_last_col && (r_r == RW'(L_OH-1));
      w_nc       = w_last_col ? '0 : r_c + 1'b1;
      w_nr       = w_last_col ? r_r + 1'b1 : r_r;
`ifdef CONV1_SCHED_WINDOW_REUSE_EN
      w_next_reuse = (w_nc != '0);
`else
      w_next_reuse = 1'b0;
`endif
      w_first_kc = w_next_reuse ? KW'(K-1) : '0;
      // A reuse fetch walks only down the rightmost column.
      w_last_rd  = (r_kr == KW'(K-1)) && (r_reuse || r_kc == KW'(K-1));
      if (r_reuse || r_kc == KW'(K-1)) begin
         w_nkr = r_kr + 1'b1;
         w_nkc = r_reuse ? r_kc : '0;
      end else begin
         w_nkr = r_kr;
         w_nkc = r_kc + 1'b1;
      end
      w_out_lin  = 32'(r_r) * 32'(L_OW) + 32'(r_c);
      w_out_addr = w_out_lin[OAW-1:0];
   end

   // The shift lands in the first reuse fetch cycle, before any capture of that window.
   assign w_shift     = (r_state == S_FETCH) && r_reuse && (r_kr == '0);
   assign out_wr_en   = (r_state == S_WAIT_RES) && conv_ready;
   assign out_wr_addr = out_wr_en ? w_out_addr : '0;
   assign out_wr_data = out_wr_en ? conv_out : '0;

   conv1_window_reg #(.K(K), .DATA_W(DATA_W)) u_win (
      .clk       (clk),
      .rstn      (rstn),
      .i_wr_en   (r_cap_vld),
      .i_wr_slot (r_cap_slot),
      .i_wr_data (img_rd_data),
      .i_shift   (w_shift),
      .o_act     (conv_act)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_r         <= '0;
         r_c         <= '0;
         r_kr        <= '0;
         r_kc        <= '0;
         r_reuse     <= 1'b0;
         r_cap_vld   <= 1'b0;
         r_cap_slot  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         img_rd_en   <= 1'b0;
         img_rd_addr <= '0;
         conv_valid  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_r         <= '0;
               r_c         <= '0;
               r_kr        <= '0;
               r_kc        <= '0;
               r_reuse     <= 1'b0;
               busy        <= 1'b1;
               img_rd_en   <= 1'b1;
               img_rd_addr <= '0;
               r_state     <= S_FETCH;
            end
            S_FETCH: begin
               r_cap_vld  <= 1'b1;
               r_cap_slot <= slot_idx(32'(r_kr), 32'(r_kc));
               if (w_last_rd) begin
                  img_rd_en   <= 1'b0;
                  img_rd_addr <= '0;
                  r_state     <= S_DRAIN;
               end else begin
                  r_kr        <= w_nkr;
                  r_kc        <= w_nkc;
                  img_rd_addr <= pix_addr(r_r, r_c, w_nkr, w_nkc);
               end
            end
            S_DRAIN: begin
               r_cap_vld  <= 1'b0;
               conv_valid <= 1'b1;
               r_state    <= S_ISSUE;
            end
            S_ISSUE: begin
               conv_valid <= 1'b0;
               r_state    <= S_WAIT_RES;
            end
            S_WAIT_RES: if (conv_ready) begin
               r_r <= w_nr;
               r_c <= w_nc;
               if (w_last_pos) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_reuse     <= w_next_reuse;
                  r_kr        <= '0;
                  r_kc        <= w_first_kc;
                  img_rd_en   <= 1'b1;
                  img_rd_addr <= pix_addr(w_nr, w_nc, '0, w_first_kc);
                  r_state     <= S_FETCH;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv1_sched.sv
// Bench for conv1_sched: image memory model, conv1 stub with optional stall, scoreboarded writes.
module tb_conv1_sched;
   localparam int IMG_W = 32, IMG_H = 32, K = 5, DATA_W = 16, OUT_CH = 6;
   localparam int OW = IMG_W - K + 1, OH = IMG_H - K + 1, NPOS = OW * OH;
   localparam int AW = 10, OAW = 10, ACT_W = K*K*DATA_W, OUT_W = OUT_CH*DATA_W;
`ifdef CONV1_SCHED_WINDOW_REUSE_EN
   localparam int EXP_DONE = 6833;
   localparam int EXP_RD   = OH * (25 + (OW-1)*5);
`else
   localparam int EXP_DONE = 21953;
   localparam int EXP_RD   = NPOS * 25;
`endif

   logic clk = 0, rstn, start;
   logic busy, done, img_rd_en, conv_valid, conv_ready, out_wr_en;
   logic [AW-1:0] img_rd_addr;
   logic [DATA_W-1:0] img_rd_data;
   logic [ACT_W-1:0] conv_act;
   logic [OUT_W-1:0] conv_out, out_wr_data;
   logic [OAW-1:0] out_wr_addr;

   conv1_sched dut (
      .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
      .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
      .conv_valid(conv_valid), .conv_act(conv_act), .conv_ready(conv_ready),
      .conv_out(conv_out), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
      .out_wr_data(out_wr_data)
   );

   // ---------------- clock / cycle counter ----------------
   int cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- image memory and conv1 stub ----------------
   always @(posedge clk) if (img_rd_en) img_rd_data <= DATA_W'(img_rd_addr);

   function automatic logic [OUT_W-1:0] hash(input logic [ACT_W-1:0] act);
      logic [OUT_W-1:0] o;
      logic [15:0] acc, px;
      for (int ch = 0; ch < OUT_CH; ch++) begin
         acc = '0;
         for (int i = 0; i < K*K; i++) begin
            px  = act[i*16 +: 16];
            acc = acc + 16'(px * 16'(i + 7*ch + 1));
         end
         o[ch*16 +: 16] = acc;
      end
      return o;
   endfunction

   function automatic logic [ACT_W-1:0] exp_window(input int r, input int c);
      logic [ACT_W-1:0] w;
      for (int kr = 0; kr < K; kr++)
         for (int kc = 0; kc < K; kc++)
            w[(kr*K+kc)*16 +: 16] = 16'((r+kr)*IMG_W + c + kc);
      return w;
   endfunction

   int stall_cycles, st_cnt;
   logic st_pend;
   logic [ACT_W-1:0] st_act;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         conv_ready <= 0; conv_out <= '0; st_pend <= 0; st_cnt <= 0; st_act <= '0;
      end else begin
         conv_ready <= 0;
         if (conv_valid) begin
            if (stall_cycles == 0) begin conv_ready <= 1; conv_out <= hash(conv_act); end
            else begin st_pend <= 1; st_cnt <= stall_cycles; st_act <= conv_act; end
         end else if (st_pend) begin
            if (st_cnt == 1) begin conv_ready <= 1; conv_out <= hash(st_act); st_pend <= 0; end
            st_cnt <= st_cnt - 1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   int tests = 0, fails = 0;
   logic [OAW+OUT_W-1:0] exp_q[$];
   logic [ACT_W-1:0] exp_act_q[$];
   logic [ACT_W-1:0] act_log[$];
   logic [AW-1:0] rd_log[$];
   int rd_cnt, wr_cnt, valid_cnt, done_cnt, first_wr_cyc, last_wr_cyc, done_cyc;
   int rd_at_wr1, valid_at_wr1, start_cyc;

   task automatic check(input string name, input logic [ACT_W-1:0] act, input logic [ACT_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: event missing or queue empty", name);
   endtask

   always @(negedge clk) if (rstn) begin
      if (img_rd_en) begin
         rd_cnt++;
         if (rd_log.size() < 60) rd_log.push_back(img_rd_addr);
      end
      if (conv_valid) begin
         valid_cnt++;
         if (act_log.size() < 2) act_log.push_back(conv_act);
         if (exp_act_q.size() == 0) fail_now("conv_act_extra");
         else check("conv_act", conv_act, exp_act_q.pop_front());
      end
      if (out_wr_en) begin
         wr_cnt++;
         if (wr_cnt == 1) begin first_wr_cyc = cyc; rd_at_wr1 = rd_cnt; valid_at_wr1 = valid_cnt; end
         last_wr_cyc = cyc;
         if (exp_q.size() == 0) fail_now("out_wr_extra");
         else check("out_wr", {out_wr_addr, out_wr_data}, exp_q.pop_front());
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
   end

   // ---------------- driver tasks ----------------
   task automatic do_start();
      logic [ACT_W-1:0] w;
      exp_q.delete(); exp_act_q.delete(); rd_log.delete(); act_log.delete();
      rd_cnt = 0; wr_cnt = 0; valid_cnt = 0; done_cnt = 0;
      first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
      for (int r = 0; r < OH; r++)
         for (int c = 0; c < OW; c++) begin
            w = exp_window(r, c);
            exp_act_q.push_back(w);
            exp_q.push_back({OAW'(r*OW + c), hash(w)});
         end
      @(posedge clk); #1;
      start = 1; start_cyc = cyc;
      check("busy_in_start_cycle", busy, 0);
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic wait_writes(input int n, input int budget, input string name);
      int k;
      for (k = 0; k < budget; k++) begin
         if (wr_cnt >= n) break;
         @(posedge clk); #1;
      end
      if (k == budget) fail_now(name);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_rd_en"}, img_rd_en, 0);
      check({tag, "_rd_addr"}, img_rd_addr, 0);
      check({tag, "_valid"}, conv_valid, 0);
      check({tag, "_act"}, conv_act, 0);
      check({tag, "_wr_en"}, out_wr_en, 0);
      check({tag, "_wr_addr"}, out_wr_addr, 0);
      check({tag, "_wr_data"}, out_wr_data, 0);
   endtask

   // ---------------- expected read-address table ----------------
   typedef struct { int idx; int exp_addr; } rd_vec_t;
   rd_vec_t rd_tab[$];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
      $fatal(1);
   end

   initial begin
      for (int kr = 0; kr < K; kr++)
         for (int kc = 0; kc < K; kc++)
            rd_tab.push_back('{kr*K + kc, kr*IMG_W + kc});
`ifdef CONV1_SCHED_WINDOW_REUSE_EN
      for (int kr = 0; kr < K; kr++) rd_tab.push_back('{25 + kr, kr*IMG_W + 5});
`else
      for (int kr = 0; kr < K; kr++)
         for (int kc = 0; kc < K; kc++)
            rd_tab.push_back('{25 + kr*K + kc, kr*IMG_W + kc + 1});
`endif

      rstn = 0; start = 0; stall_cycles = 0;
      repeat (3) @(posedge clk); #1;
      check_idle("reset");
      rstn = 1;
      repeat (2) @(posedge clk); #1;

      // Full pass, with a second start pulse at cycle 100 that must be ignored.
      do_start();
      check("busy_after_start", busy, 1);
      check("first_rd_en", img_rd_en, 1);
      check("first_rd_addr", img_rd_addr, 0);
      repeat (99) @(posedge clk); #1;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      begin
         int k;
         for (k = 0; k < 30000; k++) begin
            if (done_cnt > 0) break;
            @(posedge clk); #1;
         end
         if (k == 30000) fail_now("done_timeout");
      end
      repeat (40) @(posedge clk); #1;
      check("done_count", done_cnt, 1);
      check("write_count", wr_cnt, NPOS);
      check("valid_count", valid_cnt, NPOS);
      check("exp_q_left", exp_q.size(), 0);
      check("read_count", rd_cnt, EXP_RD);
      check("first_write_cycle", first_wr_cyc - start_cyc, 28);
      check("last_write_cycle", last_wr_cyc - start_cyc, EXP_DONE - 1);
      check("done_cycle", done_cyc - start_cyc, EXP_DONE);
      check("busy_after_done", busy, 0);
      foreach (rd_tab[i]) begin
         if (rd_tab[i].idx < rd_log.size())
            check($sformatf("rd_addr[%0d]", rd_tab[i].idx), rd_log[rd_tab[i].idx], rd_tab[i].exp_addr);
         else fail_now($sformatf("rd_addr[%0d]", rd_tab[i].idx));
      end
      if (act_log.size() == 2) begin
         check("win0_slot24", act_log[0][24*16 +: 16], 132);
         check("win1_slot0", act_log[1][0 +: 16], 1);
         check("win1_slot24", act_log[1][24*16 +: 16], 133);
      end else fail_now("act_log");

      // Stalled conv_ready on the first window.
      stall_cycles = 10;
      do_start();
      wait_writes(1, 200, "stall_write_timeout");
      check("stall_write_cycle", first_wr_cyc - start_cyc, 38);
      check("stall_valid_pulses", valid_at_wr1, 1);
      check("stall_reads", rd_at_wr1, 25);
      rstn = 0;
      repeat (2) @(posedge clk); #1;
      rstn = 1;
      stall_cycles = 0;
      @(posedge clk); #1;

      // Reset during the fetch of window 10, then restart.
      do_start();
      wait_writes(9, 400, "midpass_timeout");
      repeat (3) @(posedge clk); #1;
      check("midpass_in_fetch", img_rd_en, 1);
      rstn = 0;
      #1;
      check_idle("midreset");
      repeat (2) @(posedge clk); #1;
      rstn = 1;
      @(posedge clk); #1;
      do_start();
      wait_writes(1, 200, "restart_timeout");
      check("restart_write_count", wr_cnt, 1);
      check("restart_write_cycle", first_wr_cyc - start_cyc, 28);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
